// File: rtl/vga_pkg.sv
// Shared 640x480 VGA timing constants and counter width, used by vga_sync and the renderer.
package vga_pkg;

  localparam int unsigned CntW = 10;

  localparam int unsigned HActive = 640;
  localparam int unsigned HFp     = 16;
  localparam int unsigned HSync   = 96;
  localparam int unsigned HBp     = 48;
  localparam int unsigned VActive = 480;
  localparam int unsigned VFp     = 10;
  localparam int unsigned VSync   = 2;
  localparam int unsigned VBp     = 33;

  localparam int unsigned HTotal     = HActive + HFp + HSync + HBp;
  localparam int unsigned VTotal     = VActive + VFp + VSync + VBp;
  localparam int unsigned HSyncStart = HActive + HFp;
  localparam int unsigned HSyncEnd   = HSyncStart + HSync - 1;
  localparam int unsigned VSyncStart = VActive + VFp;
  localparam int unsigned VSyncEnd   = VSyncStart + VSync - 1;

  // True when lo <= v < lo + len.
  function automatic logic in_window(logic [CntW-1:0] v, int unsigned lo, int unsigned len);
    int unsigned vi;
    vi = 32'(v);
    return (vi >= lo) && (vi < lo + len);
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for a level generated in the clk domain; delay flop resets high.
module rise_detect (
  input  logic clk_i,
  input  logic clr_i,
  input  logic d_i,
  output logic rise_o
);

  logic d_q;

  // Resetting high keeps a level that is already high at release from looking like an edge.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      d_q <= 1'b1;
    end else begin
      d_q <= d_i;
    end
  end

  assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/vga_sync.sv
// VGA timing generator: turns dclk rising edges into pixel strobes and drives counters and syncs.
module vga_sync
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = HActive,
  parameter int unsigned H_FP     = HFp,
  parameter int unsigned H_SYNC   = HSync,
  parameter int unsigned H_BP     = HBp,
  parameter int unsigned V_ACTIVE = VActive,
  parameter int unsigned V_FP     = VFp,
  parameter int unsigned V_SYNC   = VSync,
  parameter int unsigned V_BP     = VBp
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            dclk,
  output logic            pix_stb,
  output logic [CntW-1:0] hc,
  output logic [CntW-1:0] vc,
  output logic            hsync,
  output logic            vsync,
  output logic            video_on,
  output logic            frame_start
);

  localparam int unsigned HTot = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTot = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [CntW-1:0] HLast = CntW'(HTot - 1);
  localparam logic [CntW-1:0] VLast = CntW'(VTot - 1);

  if (HTot > 1024 || VTot > 1024) begin : gen_bad_timing
    $error("vga_sync: line or frame total exceeds the counter range");
  end

  logic tick;

  rise_detect u_rise (
    .clk_i  (clk),
    .clr_i  (clr),
    .d_i    (dclk),
    .rise_o (tick)
  );

  logic [CntW-1:0] hc_q, hc_d, vc_q, vc_d;
  logic            hsync_q, hsync_d, vsync_q, vsync_d;
  logic            video_on_q, video_on_d;
  logic            pix_stb_q, frame_start_q, frame_start_d;

  always_comb begin
    hc_d = hc_q;
    vc_d = vc_q;
    if (tick) begin
      if (hc_q == HLast) begin
        hc_d = '0;
        vc_d = (vc_q == VLast) ? '0 : vc_q + 1'b1;
      end else begin
        hc_d = hc_q + 1'b1;
      end
    end
  end

  // Decode from next-state counters so syncs line up with hc/vc in the same cycle.
  always_comb begin
    hsync_d       = ~in_window(hc_d, H_ACTIVE + H_FP, H_SYNC);
    vsync_d       = ~in_window(vc_d, V_ACTIVE + V_FP, V_SYNC);
    video_on_d    = (32'(hc_d) < H_ACTIVE) && (32'(vc_d) < V_ACTIVE);
    frame_start_d = tick && (hc_d == '0) && (vc_d == '0);
  end

  // Reset parks on the last pixel of a frame so the first tick lands on (0,0).
  always_ff @(posedge clk) begin
    if (clr) begin
      hc_q          <= HLast;
      vc_q          <= VLast;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b0;
      pix_stb_q     <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      pix_stb_q     <= tick;
      frame_start_q <= frame_start_d;
    end
  end

  assign pix_stb     = pix_stb_q;
  assign hc          = hc_q;
  assign vc          = vc_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync.sv
// Bench for vga_sync: default and small-timing instances share dclk/clr, checked against a tick-count model.
module tb_vga_sync;

  logic clk = 1'b0;
  logic clr = 1'b1;
  logic dclk = 1'b1;

  always #5 clk = ~clk;

  logic       d_stb, d_hs, d_vs, d_vo, d_fs;
  logic [9:0] d_hc, d_vc;
  logic       s_stb, s_hs, s_vs, s_vo, s_fs;
  logic [9:0] s_hc, s_vc;

  vga_sync u_def (
    .clk         (clk),
    .clr         (clr),
    .dclk        (dclk),
    .pix_stb     (d_stb),
    .hc          (d_hc),
    .vc          (d_vc),
    .hsync       (d_hs),
    .vsync       (d_vs),
    .video_on    (d_vo),
    .frame_start (d_fs)
  );

  vga_sync #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1)
  ) u_small (
    .clk         (clk),
    .clr         (clr),
    .dclk        (dclk),
    .pix_stb     (s_stb),
    .hc          (s_hc),
    .vc          (s_vc),
    .hsync       (s_hs),
    .vsync       (s_vs),
    .video_on    (s_vo),
    .frame_start (s_fs)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    int   hc;
    int   vc;
    logic hs;
    logic vs;
    logic vo;
  } pos_t;

  // Position after t ticks since reset; reset sits on the final pixel of a frame.
  function automatic pos_t model(input int t, input int ha, input int hf, input int hs,
                                 input int hb, input int va, input int vf, input int vs,
                                 input int vb);
    pos_t r;
    int ht, vt, lin;
    ht   = ha + hf + hs + hb;
    vt   = va + vf + vs + vb;
    lin  = (ht * vt - 1 + t) % (ht * vt);
    r.hc = lin % ht;
    r.vc = lin / ht;
    r.hs = !(r.hc >= ha + hf && r.hc < ha + hf + hs);
    r.vs = !(r.vc >= va + vf && r.vc < va + vf + vs);
    r.vo = (r.hc < ha) && (r.vc < va);
    return r;
  endfunction

  int   ticks   = 0;
  logic dprev   = 1'b1;
  logic exp_stb = 1'b0;
  bit   run_chk = 1'b0;
  int   s_fs_cnt = 0;

  always @(posedge clk) begin
    if (clr) begin
      ticks   <= 0;
      dprev   <= 1'b1;
      exp_stb <= 1'b0;
    end else begin
      dprev   <= dclk;
      exp_stb <= dclk & ~dprev;
      if (dclk && !dprev) ticks <= ticks + 1;
    end
  end

  always @(negedge clk) begin
    if (run_chk) begin
      pos_t e, f;
      e = model(ticks, 640, 16, 96, 48, 480, 10, 2, 33);
      f = model(ticks, 8, 2, 3, 2, 4, 1, 1, 1);
      chk("def.pix_stb", int'(d_stb), int'(exp_stb));
      chk("def.hc", int'(d_hc), e.hc);
      chk("def.vc", int'(d_vc), e.vc);
      chk("def.hsync", int'(d_hs), int'(e.hs));
      chk("def.vsync", int'(d_vs), int'(e.vs));
      chk("def.video_on", int'(d_vo), int'(e.vo));
      chk("def.frame_start", int'(d_fs), int'(exp_stb && e.hc == 0 && e.vc == 0));
      chk("sm.pix_stb", int'(s_stb), int'(exp_stb));
      chk("sm.hc", int'(s_hc), f.hc);
      chk("sm.vc", int'(s_vc), f.vc);
      chk("sm.hsync", int'(s_hs), int'(f.hs));
      chk("sm.vsync", int'(s_vs), int'(f.vs));
      chk("sm.video_on", int'(s_vo), int'(f.vo));
      chk("sm.frame_start", int'(s_fs), int'(exp_stb && f.hc == 0 && f.vc == 0));
      if (s_fs) s_fs_cnt++;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input int hi, input int lo);
    dclk = 1'b1;
    step(hi);
    dclk = 1'b0;
    step(lo);
  endtask

  initial begin
    int nt;
    clr  = 1'b1;
    dclk = 1'b1;
    step(3);
    run_chk = 1'b1;

    // Release with dclk held high: no strobe, still parked on the last pixel.
    clr = 1'b0;
    step(4);
    chk("rel.no_stb", int'(d_stb), 0);
    chk("rel.hc", int'(d_hc), 799);
    chk("rel.vc", int'(d_vc), 524);

    dclk = 1'b0;
    step(4);
    dclk = 1'b1;
    step(1);
    chk("first.stb", int'(d_stb), 1);
    chk("first.hc", int'(d_hc), 0);
    chk("first.vc", int'(d_vc), 0);
    chk("first.fs", int'(d_fs), 1);
    chk("first.vo", int'(d_vo), 1);
    chk("first.hs", int'(d_hs), 1);
    chk("first.vs", int'(d_vs), 1);
    chk("first.sm_fs", int'(s_fs), 1);
    step(3);
    dclk = 1'b0;
    step(4);
    repeat (3) pulse(4, 4);

    // Irregular phases.
    pulse(1, 3);
    pulse(5, 2);
    nt = 6;
    chk("irr.hc", int'(d_hc), 5);

    while (nt < 2301) begin
      pulse($urandom_range(1, 2), $urandom_range(1, 3));
      nt++;
      if (nt == 641) chk("line.vo_fall", int'(d_vo), 0);
      if (nt == 657) chk("line.hs_low", int'(d_hs), 0);
      if (nt == 752) chk("line.hs_last", int'(d_hs), 0);
      if (nt == 753) chk("line.hs_high", int'(d_hs), 1);
      if (nt == 801) begin
        chk("line.wrap_hc", int'(d_hc), 0);
        chk("line.wrap_vc", int'(d_vc), 1);
      end
    end
    chk("pre_clr.hc", int'(d_hc), 700);
    chk("pre_clr.hs", int'(d_hs), 0);

    // Clear coinciding with a tick.
    dclk = 1'b1;
    clr  = 1'b1;
    step(1);
    chk("clr.hc", int'(d_hc), 799);
    chk("clr.vc", int'(d_vc), 524);
    chk("clr.hs", int'(d_hs), 1);
    chk("clr.stb", int'(d_stb), 0);
    chk("clr.sm_hc", int'(s_hc), 14);
    chk("clr.sm_vc", int'(s_vc), 6);
    clr = 1'b0;
    step(2);
    dclk = 1'b0;
    step(1);
    s_fs_cnt = 0;
    nt = 0;

    while (nt < 8000) begin
      pulse($urandom_range(1, 2), $urandom_range(1, 2));
      nt++;
      if (nt == 11) begin
        chk("sm.hs_window", int'(s_hs), 0);
        chk("sm.hc10", int'(s_hc), 10);
      end
      if (nt == 14) chk("sm.hs_after", int'(s_hs), 1);
      if (nt == 76) begin
        chk("sm.vc5", int'(s_vc), 5);
        chk("sm.vs_low", int'(s_vs), 0);
        chk("sm.vo_off", int'(s_vo), 0);
        chk("def.hc75", int'(d_hc), 75);
      end
      if (nt == 91) chk("sm.vs_after", int'(s_vs), 1);
      if (nt == 106) chk("sm.vc_wrap", int'(s_vc), 0);
    end
    step(2);
    chk("sm.frame_count", s_fs_cnt, (nt + 104) / 105);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
